bcd_count_ctrl: RTL
===================

Name: bcd_count_ctrl

Overview:
- Run/pause/clear controller for a chain of cascaded single-digit BCD counters (Trigger/Cin/Reset/Cout digit interface).
- Converts StartStop and Clear button levels into clean events and runs a 4-state FSM.
- Generates the periodic count Trigger from a clock prescaler, drives digit-chain Cin and DigitReset, and detects full-chain overflow through the MSD carry-out.
- Sits between the Basys3 button inputs and the digit chain.

Parameters:
- TICK_DIV, 100000, clock cycles per count tick; must be at least 2.
- CNT_W, 17, prescaler counter width; requires 2^CNT_W >= TICK_DIV.

Ports:
- Clk  in  1  system clock; everything is rising-edge.
- Reset  in  1  synchronous, active-high reset.
- StartStop  in  1  asynchronous button level; a rising edge is one run/pause event.
- Clear  in  1  asynchronous button level; a rising edge is one clear event.
- HaltOnOverflow  in  1  level; 1 = stop at all-9s, 0 = wrap to 0.
- ChainCout  in  1  Cout of the most-significant digit (combinational all-9s AND Cin).
- Trigger  out  1  one-cycle count pulse to every digit.
- Cin  out  1  carry-in to the least-significant digit.
- DigitReset  out  1  synchronous reset to every digit.
- State  out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 HALT.
- Overflow  out  1  sticky overflow flag.

Behaviour:
- All outputs are registered.
- Reset high at an edge sets State=IDLE, Trigger=0, Cin=0, DigitReset=1, Overflow=0, prescaler P=0, and clears synchronizer/edge registers to 0.
- While Reset is held, DigitReset stays 1. It drops on the first edge with Reset low.
- Input conditioning, per button: 2-flop synchronizer plus a previous-value register. The event is s2 & ~prev.
  - Input first sampled high at edge k: the event is processed at edge k+2, so the State change is visible after edge k+2.
  - Holding the button produces exactly one event.
- FSM transitions (event evaluation at each edge):
  - Clear event in any state: State becomes IDLE, DigitReset=1 for exactly one cycle, P=0, Overflow=0.
  - IDLE: StartStop goes to RUN.
  - RUN: StartStop goes to PAUSE.
  - PAUSE: StartStop goes to RUN.
  - HALT: StartStop is ignored; only Clear or Reset leaves HALT.
  - Clear and StartStop events at the same edge: Clear wins and StartStop is discarded.
- Cin is 1 exactly when the registered State is RUN; 0 otherwise.
- Prescaler, at each edge while State=RUN with no Clear event:
  - If P==TICK_DIV-1, then P=0 and a tick occurs. Otherwise P=P+1 and Trigger=0.
  - In PAUSE, P holds, so the partial period resumes.
  - In IDLE and HALT, P=0 and Trigger=0.
  - First Trigger occurs TICK_DIV edges after the edge that enters RUN from IDLE. The period is exactly TICK_DIV cycles.
- Tick handling, with ChainCout sampled at the tick edge:
  - ChainCout=0: Trigger=1 for one cycle.
  - ChainCout=1 and HaltOnOverflow=0: Trigger=1 and Overflow=1. The chain wraps to all-0.
  - ChainCout=1 and HaltOnOverflow=1: Trigger=0 (tick suppressed), Overflow=1, State becomes HALT. The chain holds all-9s.
- Overflow is set only by the conditions above and cleared only by Reset or Clear.
- A StartStop event at the same edge as a tick:
  - The tick is processed first (Trigger=1 or HALT).
  - The FSM then moves to PAUSE unless it went to HALT.
- Reset asserted mid-RUN or mid-PAUSE: all registers take their reset values at that edge, and no further Trigger is issued.
- Trigger and DigitReset are never high in the same cycle.

Test Plan (TICK_DIV=4):
1. Reset for 2 cycles → State=00, Trigger=0, Cin=0, Overflow=0, DigitReset=1 while Reset is held and 0 one cycle after release.
2. StartStop rises and is held for 10 cycles → State=01 after edge k+2 and Cin=1. Trigger pulses on the 4th, 8th, and 12th edges after entering RUN, each one cycle wide; no second event from the held button.
3. Run 6 edges, StartStop, wait 20 cycles, StartStop → State goes 01→10→01. No Trigger during PAUSE; the next Trigger comes 2 edges after resuming.
4. HaltOnOverflow=1, force ChainCout=1 at a tick edge → Trigger stays 0, State=11, Overflow=1, Cin=0. A further StartStop leaves State=11.
5. HaltOnOverflow=0, force ChainCout=1 at a tick edge → Trigger=1, Overflow=1, State stays 01.
6. Clear and StartStop rise on the same cycle while in RUN → State=00, DigitReset=1 for exactly one cycle, Overflow=0, then no Trigger for 20 cycles.

Source files
------------

// File: rtl/bcd_count_ctrl.sv
// Run/pause/clear controller for a cascaded BCD digit chain: button edge events, prescaled Trigger, Cin/DigitReset, overflow detect.
// Buttons act 2 edges after first sample; all outputs registered; no backpressure (digits accept every pulse).
module bcd_count_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       StartStop,
    input  logic       Clear,
    input  logic       HaltOnOverflow,
    input  logic       ChainCout,
    output logic       Trigger,
    output logic       Cin,
    output logic       DigitReset,
    output logic [1:0] State,
    output logic       Overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        HALT  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(TICK_DIV - 1);

    logic ss_s1_q, ss_s2_q, ss_prev_q;
    logic clr_s1_q, clr_s2_q, clr_prev_q;
    logic ss_ev, clr_ev;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic             trig_q, trig_d;
    logic             cin_q, cin_d;
    logic             drst_q, drst_d;
    logic             ovf_q, ovf_d;

    assign ss_ev  = ss_s2_q & ~ss_prev_q;
    assign clr_ev = clr_s2_q & ~clr_prev_q;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        trig_d  = 1'b0;
        drst_d  = 1'b0;
        ovf_d   = ovf_q;
        if (clr_ev) begin
            // Clear overrides everything, including a coincident tick or StartStop.
            state_d = IDLE;
            p_d     = '0;
            drst_d  = 1'b1;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    p_d = '0;
                    if (ss_ev) state_d = RUN;
                end
                RUN: begin
                    if (p_q == P_LAST) begin
                        p_d = '0;
                        if (ChainCout && HaltOnOverflow) begin
                            ovf_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            trig_d = 1'b1;
                            if (ChainCout) ovf_d = 1'b1;
                        end
                    end else begin
                        p_d = p_q + CNT_W'(1);
                    end
                    // Tick is resolved first; a pause cannot rescue the chain from HALT.
                    if (ss_ev && state_d != HALT) state_d = PAUSE;
                end
                PAUSE: begin
                    if (ss_ev) state_d = RUN;
                end
                HALT: begin
                    p_d = '0;
                end
            endcase
        end
        cin_d = (state_d == RUN);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ss_s1_q    <= 1'b0;
            ss_s2_q    <= 1'b0;
            ss_prev_q  <= 1'b0;
            clr_s1_q   <= 1'b0;
            clr_s2_q   <= 1'b0;
            clr_prev_q <= 1'b0;
            state_q    <= IDLE;
            p_q        <= '0;
            trig_q     <= 1'b0;
            cin_q      <= 1'b0;
            drst_q     <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            ss_s1_q    <= StartStop;
            ss_s2_q    <= ss_s1_q;
            ss_prev_q  <= ss_s2_q;
            clr_s1_q   <= Clear;
            clr_s2_q   <= clr_s1_q;
            clr_prev_q <= clr_s2_q;
            state_q    <= state_d;
            p_q        <= p_d;
            trig_q     <= trig_d;
            cin_q      <= cin_d;
            drst_q     <= drst_d;
            ovf_q      <= ovf_d;
        end
    end

    assign Trigger    = trig_q;
    assign Cin        = cin_q;
    assign DigitReset = drst_q;
    assign State      = state_q;
    assign Overflow   = ovf_q;

endmodule
